// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Purpose : Shared Wishbone definitions: bus widths and the response record
//           carried through response pipelines by bus slaves.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  // One response slot: valid marks a completed request, err selects err vs ack.
  typedef struct packed {
    logic             valid;
    logic             err;
    logic [WB_DW-1:0] data;
  } wb_resp_t;

  localparam wb_resp_t WB_RESP_IDLE = '{valid: 1'b0, err: 1'b0, data: '0};

endpackage
`default_nettype wire

// File: rtl/wb_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module  : wb_resp_pipe
// Purpose : LAT-stage delay line of Wishbone response records with a
//           synchronous flush that empties every stage at once.
// Ports   : i_clk   - clock
//           i_flush - clears all stages at this edge (reset or bus abort)
//           i_resp  - response record entering stage 0
//           o_resp  - response record leaving the last stage
// Revision: 1.0 - initial release
// ============================================================================
module wb_resp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic     i_clk,
  input  logic     i_flush,
  input  wb_resp_t i_resp,
  output wb_resp_t o_resp
);

  wb_resp_t stage_q [LAT];
  wb_resp_t stage_d [LAT];

  always_comb begin
    for (int i = 0; i < int'(LAT); i++) begin
      stage_d[i] = WB_RESP_IDLE;
    end
    if (!i_flush) begin
      stage_d[0] = i_resp;
      for (int i = 1; i < int'(LAT); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < int'(LAT); i++) begin
      stage_q[i] <= stage_d[i];
    end
  end

  assign o_resp = stage_q[LAT-1];

endmodule
`default_nettype wire

// File: rtl/wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : wb_mem_responder
// Purpose : Pipelined Wishbone slave backed by a single-port word memory.
//           Accepts one request per cycle (minus programmed wait states),
//           answers ack/err a fixed LAT cycles after acceptance, and flags
//           out-of-window addresses with err.
// Ports   : i_clk, i_rst      - clock, synchronous active-high reset
//           i_wb_cyc/stb/we   - bus cycle, strobe, write enable
//           i_wb_addr         - word address (AW bits)
//           i_wb_data/sel     - write data and byte enables (bit 3 = 31:24)
//           o_wb_ack/err      - one-cycle completion, OK or error
//           o_wb_stall        - request not accepted this cycle (registered)
//           o_wb_data         - read data, zero whenever o_wb_ack is low
// Revision: 1.0 - initial release
// ============================================================================
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int unsigned    AW      = 32,
  parameter int unsigned    LGMEMSZ = 10,
  parameter logic [AW-1:0]  BASE    = '0,
  parameter int unsigned    LAT     = 1,
  parameter int unsigned    WAIT    = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [WB_DW-1:0]   i_wb_data,
  input  logic [WB_SELW-1:0] i_wb_sel,
  output logic               o_wb_ack,
  output logic               o_wb_stall,
  output logic               o_wb_err,
  output logic [WB_DW-1:0]   o_wb_data
);

  localparam int unsigned MEM_DEPTH = 2 ** LGMEMSZ;
  localparam logic [2:0]  WAIT_CNT  = 3'(WAIT);

  logic [WB_DW-1:0] mem_q [MEM_DEPTH];

  // Unsigned AW-bit subtraction: addresses below BASE wrap to huge offsets
  // and therefore fall outside the window.
  logic [AW-1:0]      offset;
  logic [LGMEMSZ-1:0] mem_idx;
  logic               in_range;

  assign offset  = i_wb_addr - BASE;
  assign mem_idx = offset[LGMEMSZ-1:0];

  generate
    if (LGMEMSZ >= AW) begin : g_full_span
      assign in_range = 1'b1;
    end else begin : g_window
      assign in_range = (offset[AW-1:LGMEMSZ] == '0);
    end
  endgenerate

  // Bus abort and reset both empty the response pipe and the stall counter.
  logic flush;
  logic accept;
  logic stall_q, stall_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;

  assign flush  = i_rst | ~i_wb_cyc;
  assign accept = i_wb_cyc & i_wb_stb & ~stall_q & ~i_rst;

  // Stall is registered from the next counter value, so it never depends on
  // the current strobe.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_q != 3'd0) begin
      stall_cnt_d = stall_cnt_q - 3'd1;
    end
    if (accept) begin
      stall_cnt_d = WAIT_CNT;
    end
    if (flush) begin
      stall_cnt_d = 3'd0;
    end
    stall_d = (stall_cnt_d != 3'd0);
  end

  always_ff @(posedge i_clk) begin
    stall_cnt_q <= stall_cnt_d;
    stall_q     <= stall_d;
  end

  // Byte-enabled write; memory contents survive reset.
  logic wr_en;
  assign wr_en = accept & i_wb_we & in_range;

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < WB_SELW; b++) begin
        if (i_wb_sel[b]) begin
          mem_q[mem_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at the acceptance edge, before that edge's write
  // lands; only one request can be accepted per cycle so no bypass is needed.
  wb_resp_t resp_in;
  wb_resp_t resp_out;

  always_comb begin
    resp_in = WB_RESP_IDLE;
    if (accept) begin
      resp_in.valid = 1'b1;
      resp_in.err   = ~in_range;
      if (in_range && !i_wb_we) begin
        resp_in.data = mem_q[mem_idx];
      end
    end
  end

  wb_resp_pipe #(
    .LAT (LAT)
  ) u_resp_pipe (
    .i_clk   (i_clk),
    .i_flush (flush),
    .i_resp  (resp_in),
    .o_resp  (resp_out)
  );

  // Data is only ever non-zero in read-ack records, so it passes straight out.
  assign o_wb_ack   = resp_out.valid & ~resp_out.err;
  assign o_wb_err   = resp_out.valid &  resp_out.err;
  assign o_wb_data  = resp_out.data;
  assign o_wb_stall = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_mem_responder
// Purpose : Self-checking bench. Two instances share one bus:
//           A: LAT=2, WAIT=0, BASE=0x400, 1024 words
//           B: LAT=3, WAIT=3, BASE=0,     16 words
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_mem_responder;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;

  logic        a_ack, a_stall, a_err;
  logic [31:0] a_data;
  logic        b_ack, b_stall, b_err;
  logic [31:0] b_data;

  always #5 clk = ~clk;

  wb_mem_responder #(
    .AW(32), .LGMEMSZ(10), .BASE(32'h400), .LAT(2), .WAIT(0)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(a_ack), .o_wb_stall(a_stall), .o_wb_err(a_err), .o_wb_data(a_data)
  );

  wb_mem_responder #(
    .AW(32), .LGMEMSZ(4), .BASE(32'h0), .LAT(3), .WAIT(3)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_ack(b_ack), .o_wb_stall(b_stall), .o_wb_err(b_err), .o_wb_data(b_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  // Single read on one instance; checks ack timing and data over 6 cycles.
  task automatic read_check(input string name, input bit on_b,
                            input logic [31:0] a, input logic [31:0] exp_d);
    int lat;
    logic [63:0] act, exp;
    lat = on_b ? 3 : 2;
    idle();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      act = on_b ? {30'd0, b_ack, b_err, b_data} : {30'd0, a_ack, a_err, a_data};
      exp = (k == lat) ? {30'd0, 1'b1, 1'b0, exp_d} : 64'd0;
      check($sformatf("%s_c%0d", name, k), act, exp);
      tick();
      stb = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic ea, input logic ee,
                              input logic cd, input logic [31:0] ed);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.sel = s;
    v.exp_ack = ea; v.exp_err = ee; v.chk_data = cd; v.exp_data = ed;
    return v;
  endfunction

  initial begin
    logic [63:0] act, exp;
    int j;

    // Instance A vectors, issued back-to-back (BASE = 0x400, window 0x400..0x7FF)
    tbl[0]  = mk(1, 32'h405, 32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h406, 32'hAABBCCDD, 4'hF, 1, 0, 0, 32'h0);
    tbl[2]  = mk(1, 32'h406, 32'h11223344, 4'h5, 1, 0, 0, 32'h0);
    tbl[3]  = mk(0, 32'h405, 32'h0,        4'hF, 1, 0, 1, 32'hDEADBEEF);
    tbl[4]  = mk(0, 32'h406, 32'h0,        4'hF, 1, 0, 1, 32'hAA22CC44);
    tbl[5]  = mk(0, 32'h3FF, 32'h0,        4'hF, 0, 1, 1, 32'h0);
    tbl[6]  = mk(0, 32'h800, 32'h0,        4'hF, 0, 1, 1, 32'h0);
    tbl[7]  = mk(1, 32'h400, 32'hCAFEF00D, 4'hF, 1, 0, 0, 32'h0);
    tbl[8]  = mk(1, 32'h800, 32'h12345678, 4'hF, 0, 1, 1, 32'h0);
    tbl[9]  = mk(1, 32'h400, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 32'h0);
    tbl[10] = mk(0, 32'h400, 32'h0,        4'hF, 1, 0, 1, 32'hCAFEF00D);
    tbl[11] = mk(1, 32'h7FF, 32'h0BADF00D, 4'hF, 1, 0, 0, 32'h0);
    tbl[12] = mk(0, 32'h7FF, 32'h0,        4'hF, 1, 0, 1, 32'h0BADF00D);
    tbl[13] = mk(0, 32'h405, 32'h0,        4'hF, 1, 0, 1, 32'hDEADBEEF);

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    repeat (3) tick();

    // Reset state
    check("rst_a", {28'd0, a_ack, a_err, a_stall, 1'b0, a_data}, 64'd0);
    check("rst_b", {28'd0, b_ack, b_err, b_stall, 1'b0, b_data}, 64'd0);
    rst = 1'b0;

    // Table: cycle c shows the response to vector c-2 on instance A
    idle();
    cyc = 1'b1;
    for (int c = 0; c < NVEC + 3; c++) begin
      if (c < NVEC) begin
        stb = 1'b1; we = tbl[c].we; addr = tbl[c].addr;
        wdata = tbl[c].data; sel = tbl[c].sel;
      end else begin
        stb = 1'b0; we = 1'b0;
      end
      j = c - 2;
      if (j >= 0 && j < NVEC) begin
        act = {30'd0, a_ack, a_err, tbl[j].chk_data ? a_data : 32'h0};
        exp = {30'd0, tbl[j].exp_ack, tbl[j].exp_err, tbl[j].chk_data ? tbl[j].exp_data : 32'h0};
        check($sformatf("vec%0d", j), act, exp);
      end else begin
        check($sformatf("idle_c%0d", c), {30'd0, a_ack, a_err, a_data}, 64'd0);
      end
      tick();
    end

    // Wait states on B: stb held 8 cycles, acceptances at cycles 0 and 4
    idle();
    cyc = 1'b1; we = 1'b1; addr = 32'h3; wdata = 32'h01020304; sel = 4'hF;
    for (int c = 0; c < 12; c++) begin
      stb = (c < 8);
      check($sformatf("stall_c%0d", c), {63'd0, b_stall},
            {63'd0, (c < 8) && (c % 4 != 0)});
      check($sformatf("wack_c%0d", c), {62'd0, b_ack, b_err},
            (c == 3 || c == 7) ? 64'd2 : 64'd0);
      tick();
    end
    read_check("rd_b3", 1'b1, 32'h3, 32'h01020304);

    // Abort on A: reads at cycles 0..2, cyc low in cycle 3.
    // Responses due in cycles 2 and 3 are driven; the one due in 4 is dropped.
    idle();
    cyc = 1'b1; we = 1'b0; sel = 4'hF;
    for (int c = 0; c < 8; c++) begin
      cyc = (c != 3);
      stb = (c < 3);
      addr = (c == 1) ? 32'h406 : 32'h405;
      if (c == 2)      exp = {30'd0, 2'b10, 32'hDEADBEEF};
      else if (c == 3) exp = {30'd0, 2'b10, 32'hAA22CC44};
      else             exp = 64'd0;
      check($sformatf("abort_c%0d", c), {30'd0, a_ack, a_err, a_data}, exp);
      tick();
    end

    // Reset mid-stream: B read of addr 3 and A err (addr 3 out of A's window)
    // are in flight when reset hits at the end of cycle 1.
    idle();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h3; sel = 4'hF;
    tick();
    stb = 1'b0; rst = 1'b1;
    check("rst_mid_stall_before", {63'd0, b_stall}, 64'd1);
    tick();
    rst = 1'b0;
    check("rst_mid_stall_after", {63'd0, b_stall}, 64'd0);
    for (int c = 2; c < 7; c++) begin
      check($sformatf("rst_mid_c%0d", c), {60'd0, a_ack, a_err, b_ack, b_err}, 64'd0);
      tick();
    end
    read_check("reread_b3", 1'b1, 32'h3, 32'h01020304);
    read_check("reread_a405", 1'b0, 32'h405, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Pipelined Wishbone (B4 pipelined) slave: single-port word memory that answers bus masters such as the CPU instruction fetch and memory units.
- Accepts one request per cycle, subject to programmable wait states.
- Returns ack or err after a fixed read/write latency.
- Out-of-range addresses return a bus error.
- Used as on-chip boot/instruction RAM and as the canonical responder in fetch-unit benches.

Parameters:
- AW, 32: bus word-address width.
- LGMEMSZ, 10: log2 of memory depth in 32-bit words; LGMEMSZ <= AW.
- BASE, 0: word address of memory location 0; must be aligned to 2^LGMEMSZ.
- LAT, 1: cycles from acceptance to ack/err; legal range 1..4.
- WAIT, 0: stall cycles inserted after each accepted request; legal range 0..7.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_wb_cyc  in  1  bus cycle active
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  AW  word address
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables; bit 3 = bits 31:24
- o_wb_ack  out  1  request completed OK
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_err  out  1  request completed with error
- o_wb_data  out  32  read data, valid with o_wb_ack

Behaviour:
- Reset (i_rst high at the clock edge):
  - o_wb_ack, o_wb_err and o_wb_stall go to 0; o_wb_data goes to 0.
  - Every in-flight request is discarded. No ack or err is ever issued for it.
  - Memory contents are preserved.
- Acceptance: a request is accepted in cycle n when i_wb_cyc, i_wb_stb and !o_wb_stall are all true in that cycle.
- In range: (i_wb_addr - BASE) < 2^LGMEMSZ, computed as an unsigned AW-bit subtraction. Wrap-around below BASE therefore counts as out of range.
- Accepted write, in range: at the end of cycle n, every byte with its sel bit set is written. sel = 0 writes nothing and is still acked.
- Accepted write, out of range: memory is not modified.
- Accepted read: the word is sampled at the end of cycle n. A read accepted in cycle n+1 sees a write accepted in cycle n.
- Response timing: o_wb_ack or o_wb_err is high for exactly one cycle, in cycle n+LAT.
  - Out-of-range requests get err, with o_wb_data = 0.
  - ack and err are never high together.
  - Responses come back in acceptance order; back-to-back acceptances give back-to-back responses.
- o_wb_data is 0 when o_wb_ack is low.
- Stall:
  - WAIT = 0: o_wb_stall is constantly 0.
  - WAIT > 0: after an acceptance in cycle n, o_wb_stall is 1 in cycles n+1 through n+WAIT. The counter is 3 bits and saturates at 0.
  - The stall does not depend on i_wb_stb in the current cycle, so o_wb_stall is a register output.
- Abort (i_wb_cyc low in any cycle):
  - All pending pipeline entries are cleared at that edge. o_wb_ack and o_wb_err are 0 in the following cycle.
  - The stall counter clears.
  - Writes already accepted stay committed.
- Simultaneous events:
  - Reset has priority over everything.
  - An abort in the same cycle as an stb does not accept the stb, because cyc is low.
  - A response falling due in an abort cycle is still driven in that cycle; it is registered from the prior edge.
- Pipeline state: LAT-deep shift of {valid, err, data}; no FSM beyond the stall counter. A competent RTL is about 150-200 lines.

Decomposition:
- Shared package wb_pkg:
  - WB_DW = 32, WB_SELW = 4.
  - Response typedef {valid, err, data[31:0]}, reused by future peripherals.
- One sub-module, wb_resp_pipe: parameterised LAT-stage delay line of response records with synchronous flush (driven by i_rst | !i_wb_cyc).
- Range check, memory array and stall counter stay in the top module.

Test Plan:
- Single read: preload mem[5] = 0xDEADBEEF; LAT = 2, BASE = 0; read address 5 accepted in cycle 10 -> o_wb_ack = 1 and o_wb_data = 0xDEADBEEF in cycle 12 only.
- Byte write: write 0x11223344 with sel = 4'b0101 to a word holding 0xAABBCCDD, then read it -> data 0xAA22CC44, two acks in consecutive cycles with WAIT = 0.
- Range error: BASE = 0x400, LGMEMSZ = 10.
  - Read 0x3FF and 0x800 -> o_wb_err in cycle n+LAT for each, o_wb_ack = 0, o_wb_data = 0.
  - A write to 0x800 leaves memory unchanged.
- Wait states: WAIT = 3, stb held high for 8 cycles -> acceptances exactly every 4 cycles; o_wb_stall pattern 0,1,1,1 repeating.
- Abort: LAT = 3; issue 3 reads in consecutive cycles, drop cyc the cycle after the last acceptance -> zero acks afterwards.
- Reset mid-stream: reads in flight with LAT = 4, pulse i_rst -> no ack/err after reset; o_wb_stall = 0; memory intact on re-read.
